// File: rtl/spi_master_gen_if.sv
// spi_master_gen_if
// Word-level and SPI-pin bundle for spi_master_gen. The master modport is
// the SPI master's view. The slave modport is the view of whatever sits
// around the master: the local producer/consumer plus the off-chip slaves.
//
// Signals:
//   transmit   session enable (start a word / continue a burst)
//   d_valid    data_in valid
//   data_in    word to send (DATA_WIDTH)
//   cpol/cpha  SPI mode, latched per word
//   cs_sel     slave index, latched at the first word of a burst (CS_WIDTH)
//   lsb_first  LSB-first select (only when SPI_LSB_FIRST_EN is defined)
//   MISO       serial data from slave
//   MOSI       serial data to slave
//   SCLK       serial clock
//   CS         active-low chip selects (NUM_CS)
//   ready      a word can be accepted this cycle
//   busy       session in progress or CS asserted
//   done       one-cycle pulse at word completion
//   rx         last received word (DATA_WIDTH)
//
// Optional feature macro: SPI_LSB_FIRST_EN (adds lsb_first).

interface spi_master_gen_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CS     = 1,
   parameter int CS_WIDTH   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);

   logic                  transmit;
   logic                  d_valid;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  cpol;
   logic                  cpha;
   logic [CS_WIDTH-1:0]   cs_sel;
`ifdef SPI_LSB_FIRST_EN
   logic                  lsb_first;
`endif
   logic                  MISO;
   logic                  MOSI;
   logic                  SCLK;
   logic [NUM_CS-1:0]     CS;
   logic                  ready;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] rx;

   modport master (
`ifdef SPI_LSB_FIRST_EN
      input  lsb_first,
`endif
      input  transmit, d_valid, data_in, cpol, cpha, cs_sel, MISO,
      output MOSI, SCLK, CS, ready, busy, done, rx
   );

   modport slave (
`ifdef SPI_LSB_FIRST_EN
      output lsb_first,
`endif
      output transmit, d_valid, data_in, cpol, cpha, cs_sel, MISO,
      input  MOSI, SCLK, CS, ready, busy, done, rx
   );

endinterface

// File: rtl/spi_master_gen.sv
// spi_master_gen
// Parametrised SPI master. It supports any word width, an SCLK divide ratio,
// several slave selects and all four CPOL/CPHA modes. Back-to-back words can
// share one chip-select assertion (burst).
//
// Ports:
//   CLK    system clock, all logic on the rising edge
//   reset  synchronous, active-high reset
//   bus    spi_master_gen_if.master: word handshake (transmit, d_valid,
//          data_in, ready, done, rx, busy), mode/select inputs (cpol, cpha,
//          cs_sel) and SPI pins (MISO, MOSI, SCLK, CS)
//
// Optional feature macro: SPI_LSB_FIRST_EN. When defined, bus.lsb_first is
// latched with each word and selects LSB-first shifting. Otherwise the block
// is always MSB-first.

module spi_master_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 1,
   parameter int NUM_CS     = 1,
   parameter int CS_WIDTH   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input logic              CLK,
   input logic              reset,
   spi_master_gen_if.master bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] LAST  = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_WIDTH) + 1;
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_FINAL = EDGE_W'(2 * DATA_WIDTH - 1);

   logic [1:0]            state;
   logic [NUM_CS-1:0]     cs_q;
   logic                  sclk_q;
   logic                  mosi_q;
   logic                  done_q;
   logic [DATA_WIDTH-1:0] rx_q;
   logic                  cpol_q;
   logic                  cpha_q;
   logic                  lsb_q;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DIV_W-1:0]      div_cnt;
   logic [EDGE_W-1:0]     edge_cnt;

   logic                  lsb_sel;
   logic                  ready_int;
   logic                  accept;
   logic                  leading;
   logic                  final_edge;
   logic                  sample;
   logic                  shift_out;
   logic [DATA_WIDTH-1:0] load_word;
   logic [DATA_WIDTH-1:0] rx_next;
   logic [DATA_WIDTH-1:0] rx_word;
   logic [NUM_CS-1:0]     cs_dec;

   function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] w);
      logic [DATA_WIDTH-1:0] r;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         r[i] = w[DATA_WIDTH-1-i];
      end
      return r;
   endfunction

`ifdef SPI_LSB_FIRST_EN
   assign lsb_sel = bus.lsb_first;
`else
   assign lsb_sel = 1'b0;
`endif

   // Handshake and edge classification. The shifter always works MSB-first
   // internally. LSB-first words are reversed on the way in and on the way
   // out. edge_cnt holds the number of SCLK edges already produced, so an
   // even count means the coming edge is a leading (odd-numbered) one.
   always_comb begin
      ready_int  = (state == IDLE) || (state == LAST);
      accept     = ready_int && bus.d_valid && bus.transmit;
      leading    = ~edge_cnt[0];
      final_edge = (edge_cnt == EDGE_FINAL);
      sample     = leading ^ cpha_q;
      shift_out  = cpha_q ? leading : (~leading && ~final_edge);
      load_word  = lsb_sel ? bit_reverse(bus.data_in) : bus.data_in;
      rx_next    = {rx_shift[DATA_WIDTH-2:0], bus.MISO};
      rx_word    = cpha_q ? rx_next : rx_shift;
      if (lsb_q) begin
         rx_word = bit_reverse(rx_word);
      end
      cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (bus.cs_sel == CS_WIDTH'(i)) begin
            cs_dec[i] = 1'b0;
         end
      end
   end

   // Main sequencer. A word is accepted from IDLE, or from LAST to continue
   // a burst. Only an IDLE acceptance picks up a new chip select. In SHIFT,
   // the half-period counter emits one SCLK edge every CLK_DIV cycles. The
   // final edge returns SCLK to its idle level and produces done. MISO needs
   // no synchroniser: it is only sampled on edges this block generates,
   // half an SCLK period after the slave drives it.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= IDLE;
         cs_q     <= '1;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         done_q   <= 1'b0;
         rx_q     <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         tx_shift <= '0;
         rx_shift <= '0;
         div_cnt  <= '0;
         edge_cnt <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            state    <= SHIFT;
            cpol_q   <= bus.cpol;
            cpha_q   <= bus.cpha;
            lsb_q    <= lsb_sel;
            sclk_q   <= bus.cpol;
            div_cnt  <= '0;
            edge_cnt <= '0;
            rx_shift <= '0;
            if (state == IDLE) begin
               cs_q <= cs_dec;
            end
            if (bus.cpha) begin
               mosi_q   <= 1'b0;
               tx_shift <= load_word;
            end else begin
               mosi_q   <= load_word[DATA_WIDTH-1];
               tx_shift <= {load_word[DATA_WIDTH-2:0], 1'b0};
            end
         end else begin
            case (state)
               IDLE: begin
                  mosi_q <= 1'b0;
               end
               SHIFT: begin
                  if (div_cnt == DIV_LAST) begin
                     div_cnt  <= '0;
                     sclk_q   <= ~sclk_q;
                     edge_cnt <= edge_cnt + EDGE_W'(1);
                     if (sample) begin
                        rx_shift <= rx_next;
                     end
                     if (shift_out) begin
                        mosi_q   <= tx_shift[DATA_WIDTH-1];
                        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                     end
                     if (final_edge) begin
                        state  <= LAST;
                        done_q <= 1'b1;
                        rx_q   <= rx_word;
                     end
                  end else begin
                     div_cnt <= div_cnt + DIV_W'(1);
                  end
               end
               LAST: begin
                  state  <= GAP;
                  cs_q   <= '1;
                  mosi_q <= 1'b0;
               end
               GAP: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   // While IDLE, SCLK follows the live cpol input so the slave sees the
   // correct idle level before CS falls. In every other state SCLK comes
   // from the register. ready and the idle SCLK are forced low during reset.
   assign bus.SCLK  = (state == IDLE) ? (bus.cpol & ~reset) : sclk_q;
   assign bus.ready = ready_int & ~reset;
   assign bus.busy  = (state != IDLE) || (cs_q != '1);
   assign bus.MOSI  = mosi_q;
   assign bus.CS    = cs_q;
   assign bus.done  = done_q;
   assign bus.rx    = rx_q;

endmodule
